rfphoenix_valu_sched: RTL

Issue scheduler for the shared vector ALU. It arbitrates round-robin among NREQ thread requesters and tracks in-flight operations through the ALU pipeline so results return tagged with their requester. It enforces a per-requester outstanding-op credit limit. It serialises precision changes: the ALU output precision select is global, so the pipeline must drain before prc changes. Sits between the thread issue stage and the vector ALU operand register.

---
 rtl/rfphoenix_valu_sched_if.sv | 28 ++
 rtl/rfphoenix_valu_sched.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/rfphoenix_valu_sched_if.sv
// Bundle between the thread issue stage and the vector ALU issue scheduler:
// per-requester requests and precisions in, grants plus issue/result tags out.
interface rfphoenix_valu_sched_if #(
  parameter int NREQ = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] req_prc;
  logic              hold;
  logic [NREQ-1:0]   gnt;
  logic              issue_v;
  logic [IDW-1:0]    issue_id;
  logic [1:0]        prc;
  logic              res_v;
  logic [IDW-1:0]    res_id;
  logic              busy;

  modport master (
    output req, req_prc, hold,
    input  gnt, issue_v, issue_id, prc, res_v, res_id, busy
  );

  modport slave (
    input  req, req_prc, hold,
    output gnt, issue_v, issue_id, prc, res_v, res_id, busy
  );
endinterface

// File: rtl/rfphoenix_valu_sched.sv
// Round-robin issue scheduler for the shared vector ALU with per-requester credits,
// a tagged in-flight token pipe and drain-before-switch handling of the global precision.
module rfphoenix_valu_sched #(
  parameter int NREQ   = 4,
  parameter int LAT    = 3,
  parameter int MAXOUT = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  rfphoenix_valu_sched_if.slave bus
);
  localparam int IDW = $clog2(NREQ);

  typedef enum logic {RUN, DRAIN} state_t;
  typedef logic [IDW-1:0] id_t;
  typedef logic [IDW:0]   cand_t;

  state_t     state_q, state_d;
  id_t        rr_q, rr_d;
  logic [1:0] prc_q, prc_d;
  id_t        pend_id_q, pend_id_d;
  logic [1:0] pend_prc_q, pend_prc_d;
  logic       pend_pri_q, pend_pri_d;
  logic [2:0] cnt_q [NREQ];
  logic [2:0] cnt_d [NREQ];
  logic       issue_v_q, issue_v_d;
  id_t        issue_id_q, issue_id_d;
  logic [LAT-1:0] tok_v_q, tok_v_d;
  id_t        tok_id_q [LAT];
  id_t        tok_id_d [LAT];

  logic [1:0]      prc_of [NREQ];
  logic [NREQ-1:0] elig;
  logic            win_found;
  id_t             win_id;
  cand_t           cand;
  logic            pend_ok;
  logic            sel_found;
  id_t             sel_id;
  logic [NREQ-1:0] gnt;
  logic            grant;
  logic            pipe_clear;
  logic            res_v;
  id_t             res_id;

  assign res_v  = tok_v_q[LAT-1];
  assign res_id = tok_id_q[LAT-1];
  assign grant  = |gnt;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      prc_of[i] = bus.req_prc[2*i +: 2];
      elig[i]   = bus.req[i] && (cnt_q[i] < 3'(MAXOUT));
    end
  end

  // First eligible requester at or after rr, wrapping modulo NREQ.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = cand_t'(rr_q) + cand_t'(k);
      if (cand >= cand_t'(NREQ)) cand = cand - cand_t'(NREQ);
      if (!win_found && elig[cand[IDW-1:0]]) begin
        win_found = 1'b1;
        win_id    = cand[IDW-1:0];
      end
    end
  end

  // The op still in the last stage is leaving this cycle, so it does not block the switch.
  always_comb begin
    pipe_clear = !issue_v_q;
    for (int s = 0; s < LAT - 1; s++) begin
      if (tok_v_q[s]) pipe_clear = 1'b0;
    end
  end

  assign pend_ok   = pend_pri_q && elig[pend_id_q] && (prc_of[pend_id_q] == prc_q);
  assign sel_found = pend_ok || win_found;
  assign sel_id    = pend_ok ? pend_id_q : win_id;

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    prc_d      = prc_q;
    pend_id_d  = pend_id_q;
    pend_prc_d = pend_prc_q;
    pend_pri_d = pend_pri_q && bus.hold;
    gnt        = '0;
    case (state_q)
      RUN: begin
        if (rst_n && !bus.hold && sel_found) begin
          if (prc_of[sel_id] == prc_q) begin
            gnt[sel_id] = 1'b1;
            rr_d        = (sel_id == id_t'(NREQ - 1)) ? '0 : sel_id + 1'b1;
          end else begin
            state_d    = DRAIN;
            pend_id_d  = sel_id;
            pend_prc_d = prc_of[sel_id];
            pend_pri_d = 1'b0;
          end
        end
      end
      DRAIN: begin
        if (pipe_clear) begin
          state_d    = RUN;
          prc_d      = pend_prc_q;
          pend_pri_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // A grant and a returning result on the same requester cancel out.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      cnt_d[i] = cnt_q[i];
      case ({gnt[i], res_v && (res_id == id_t'(i))})
        2'b10:   cnt_d[i] = cnt_q[i] + 3'd1;
        2'b01:   cnt_d[i] = cnt_q[i] - 3'd1;
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  always_comb begin
    issue_v_d   = grant;
    issue_id_d  = grant ? sel_id : issue_id_q;
    tok_v_d     = tok_v_q;
    tok_v_d[0]  = issue_v_q;
    tok_id_d[0] = issue_id_q;
    for (int s = 1; s < LAT; s++) begin
      tok_v_d[s]  = tok_v_q[s-1];
      tok_id_d[s] = tok_id_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RUN;
      rr_q       <= '0;
      prc_q      <= 2'd1;
      pend_id_q  <= '0;
      pend_prc_q <= '0;
      pend_pri_q <= 1'b0;
      issue_v_q  <= 1'b0;
      issue_id_q <= '0;
      tok_v_q    <= '0;
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
      for (int s = 0; s < LAT; s++) tok_id_q[s] <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      prc_q      <= prc_d;
      pend_id_q  <= pend_id_d;
      pend_prc_q <= pend_prc_d;
      pend_pri_q <= pend_pri_d;
      issue_v_q  <= issue_v_d;
      issue_id_q <= issue_id_d;
      tok_v_q    <= tok_v_d;
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= cnt_d[i];
      for (int s = 0; s < LAT; s++) tok_id_q[s] <= tok_id_d[s];
    end
  end

  assign bus.gnt      = gnt;
  assign bus.issue_v  = issue_v_q;
  assign bus.issue_id = issue_id_q;
  assign bus.prc      = prc_q;
  assign bus.res_v    = res_v;
  assign bus.res_id   = res_id;
  assign bus.busy     = (state_q == DRAIN) || issue_v_q || (|tok_v_q);
endmodule
